// File: rtl/microc_stack.sv
// Single-cycle microcontroller datapath: PC, 16x DW register file, ALU with z/c flags
// and a hardware return-address stack with a sticky overflow/underflow flag.
module microc_stack #(
   parameter int unsigned DW          = 8,
   parameter int unsigned PW          = 10,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   output logic [PW-1:0] pc,
   input  logic [PW+5:0] instr,
   output logic [5:0]    Opcode,
   output logic          z,
   output logic          c,
   output logic          stk_err,
   input  logic          s_inc,
   input  logic          s_inm,
   input  logic          we3,
   input  logic          wez,
   input  logic          s_call,
   input  logic          s_ret,
   input  logic [2:0]    Op
);

   localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned AW  = $clog2(STACK_DEPTH);

   logic [DW-1:0] regs [16];
   logic [PW-1:0] stack [STACK_DEPTH];
   logic [SPW-1:0] sp;
   logic [SPW-1:0] sp_next;

   logic [3:0]    ra1, ra2, wa3;
   logic [7:0]    imm;
   logic [DW-1:0] rd1, rd2, rd3;
   logic [DW-1:0] a, b, y;
   logic [DW:0]   wide;
   logic          k;

   logic [PW-1:0] target, pc_inc, pc_next;
   logic [AW-1:0] top_idx, push_idx;
   logic          full, empty, push, err_set;

   assign Opcode = instr[PW+5:PW];
   assign ra1    = instr[11:8];
   assign ra2    = instr[7:4];
   assign wa3    = instr[3:0];
   assign imm    = instr[11:4];
   assign target = instr[PW-1:0];
   assign pc_inc = pc + PW'(1);

   // R0 is hard-wired to zero on every read port
   assign rd1 = (ra1 == 4'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 4'd0) ? '0 : regs[ra2];
   assign rd3 = (wa3 == 4'd0) ? '0 : regs[wa3];
   assign a   = s_inm ? DW'(imm) : rd1;
   assign b   = s_inm ? rd3 : rd2;

   always_comb begin
      y    = '0;
      k    = 1'b0;
      wide = '0;
      case (Op)
         3'b000: y = a;
         3'b001: y = ~a;
         3'b010: begin
            wide = {1'b0, a} + {1'b0, b};
            y    = wide[DW-1:0];
            k    = wide[DW];
         end
         3'b011: begin
            wide = {1'b0, a} - {1'b0, b};
            y    = wide[DW-1:0];
            k    = wide[DW];
         end
         3'b100: y = a & b;
         3'b101: y = a | b;
         3'b110: y = '0 - a;
         3'b111: y = '0 - b;
      endcase
   end

   assign full     = (sp == SPW'(STACK_DEPTH));
   assign empty    = (sp == '0);
   assign top_idx  = AW'(sp - SPW'(1));
   assign push_idx = AW'(sp);

   // Return beats call; a call into a full stack still jumps but drops the push
   always_comb begin
      pc_next = s_inc ? pc_inc : target;
      sp_next = sp;
      push    = 1'b0;
      err_set = 1'b0;
      if (s_ret) begin
         if (!empty) begin
            pc_next = stack[top_idx];
            sp_next = sp - SPW'(1);
         end else begin
            pc_next = pc_inc;
            err_set = 1'b1;
         end
      end else if (s_call) begin
         pc_next = target;
         if (!full) begin
            push    = 1'b1;
            sp_next = sp + SPW'(1);
         end else begin
            err_set = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc      <= '0;
         z       <= 1'b0;
         c       <= 1'b0;
         stk_err <= 1'b0;
         sp      <= '0;
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else begin
         pc <= pc_next;
         sp <= sp_next;
         if (err_set) stk_err <= 1'b1;
         if (wez) begin
            z <= (y == '0);
            c <= k;
         end
         if (we3 && (wa3 != 4'd0)) regs[wa3] <= y;
      end
   end

   // Stack storage needs no reset: entries above sp are never read
   always_ff @(posedge clk) begin
      if (reset && push) stack[push_idx] <= pc_inc;
   end

endmodule

// File: tb/tb_microc_stack.sv
// Directed bench for microc_stack: ALU/register vector table plus call/return sequences.
module tb_microc_stack;

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 10;
   localparam int unsigned IW = PW + 6;

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] pc;
   logic [IW-1:0] instr;
   logic [5:0]    opcode;
   logic          z, c, stk_err;
   logic          s_inc, s_inm, we3, wez, s_call, s_ret;
   logic [2:0]    op;

   always #5 clk = ~clk;

   microc_stack #(.DW(DW), .PW(PW), .STACK_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .pc(pc), .instr(instr), .Opcode(opcode),
      .z(z), .c(c), .stk_err(stk_err), .s_inc(s_inc), .s_inm(s_inm),
      .we3(we3), .wez(wez), .s_call(s_call), .s_ret(s_ret), .Op(op)
   );

   typedef struct {
      logic [15:0] instr;
      logic        s_inc, s_inm, we3, wez, s_call, s_ret;
      logic [2:0]  op;
      logic [9:0]  epc;
      logic        ez, ec, eerr;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   vec_t tbl[$];
   vec_t seq[$];

   function automatic vec_t mk_alu(logic [15:0] i, logic inm, logic we, logic wz, logic [2:0] o,
                                   logic [9:0] epc, logic ez, logic ec, logic eerr);
      vec_t v;
      v.instr = i; v.s_inc = 1'b1; v.s_inm = inm; v.we3 = we; v.wez = wz;
      v.s_call = 1'b0; v.s_ret = 1'b0; v.op = o;
      v.epc = epc; v.ez = ez; v.ec = ec; v.eerr = eerr;
      return v;
   endfunction

   function automatic vec_t mk_ctl(logic [15:0] i, logic inc, logic call, logic ret,
                                   logic [9:0] epc, logic ez, logic ec, logic eerr);
      vec_t v;
      v.instr = i; v.s_inc = inc; v.s_inm = 1'b0; v.we3 = 1'b0; v.wez = 1'b0;
      v.s_call = call; v.s_ret = ret; v.op = 3'b000;
      v.epc = epc; v.ez = ez; v.ec = ec; v.eerr = eerr;
      return v;
   endfunction

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      logic [15:0] iw;
      iw     = v.instr;
      instr  = v.instr;
      s_inc  = v.s_inc;  s_inm = v.s_inm; we3 = v.we3; wez = v.wez;
      s_call = v.s_call; s_ret = v.s_ret; op  = v.op;
      #1;
      chk({name, " opcode"}, int'(opcode), int'(iw[15:10]));
      @(posedge clk);
      #1;
      chk({name, " pc"},      int'(pc),      int'(v.epc));
      chk({name, " z"},       int'(z),       int'(v.ez));
      chk({name, " c"},       int'(c),       int'(v.ec));
      chk({name, " stk_err"}, int'(stk_err), int'(v.eerr));
   endtask

   initial begin
      // ALU / register-file vectors (after reset: pc=0, flags 0, regs 0)
      tbl.push_back(mk_alu(16'h0100, 0, 0, 1, 3'b000, 10'd1,  1, 0, 0)); // R1 reads 0
      tbl.push_back(mk_alu(16'h0051, 1, 1, 1, 3'b000, 10'd2,  0, 0, 0)); // R1=05
      tbl.push_back(mk_alu(16'h0FB2, 1, 1, 1, 3'b000, 10'd3,  0, 0, 0)); // R2=FB
      tbl.push_back(mk_alu(16'h0123, 0, 1, 1, 3'b010, 10'd4,  1, 1, 0)); // R3=05+FB=00 carry
      tbl.push_back(mk_alu(16'h0003, 1, 0, 1, 3'b011, 10'd5,  1, 0, 0)); // 00-R3 = 0
      tbl.push_back(mk_alu(16'h07A0, 1, 1, 1, 3'b000, 10'd6,  0, 0, 0)); // write R0 (dropped)
      tbl.push_back(mk_alu(16'h0000, 0, 0, 1, 3'b000, 10'd7,  1, 0, 0)); // R0 still 0
      tbl.push_back(mk_alu(16'h0041, 1, 0, 1, 3'b011, 10'd8,  0, 1, 0)); // 04-05 borrow
      tbl.push_back(mk_alu(16'h0001, 1, 0, 0, 3'b011, 10'd9,  0, 1, 0)); // wez=0 holds flags
      tbl.push_back(mk_alu(16'h0FF0, 1, 0, 1, 3'b001, 10'd10, 1, 0, 0)); // ~FF = 0
      tbl.push_back(mk_alu(16'h0014, 1, 1, 1, 3'b110, 10'd11, 0, 0, 0)); // R4 = -1 = FF
      tbl.push_back(mk_alu(16'h0FF4, 1, 0, 1, 3'b011, 10'd12, 1, 0, 0)); // FF-R4 = 0
      tbl.push_back(mk_alu(16'h0210, 0, 0, 1, 3'b100, 10'd13, 0, 0, 0)); // FB&05 = 01
      tbl.push_back(mk_alu(16'h0000, 0, 0, 1, 3'b101, 10'd14, 1, 0, 0)); // 0|0
      tbl.push_back(mk_alu(16'h0001, 1, 0, 1, 3'b111, 10'd15, 0, 0, 0)); // -R1 = FB
      tbl.push_back(mk_alu(16'h0FF1, 1, 0, 1, 3'b010, 10'd16, 0, 1, 0)); // FF+05 = 04 carry
      tbl.push_back(mk_ctl(16'hFFFF, 0, 0, 0, 10'h3FF, 0, 1, 0));        // jump 3FF
      tbl.push_back(mk_ctl(16'h0000, 1, 0, 0, 10'h000, 0, 1, 0));        // wrap
      tbl.push_back(mk_ctl(16'h0000, 1, 0, 0, 10'h001, 0, 1, 0));
      tbl.push_back(mk_ctl(16'h0000, 1, 0, 0, 10'h002, 0, 1, 0));
      tbl.push_back(mk_ctl(16'h0000, 1, 0, 0, 10'h003, 0, 1, 0));
      tbl.push_back(mk_alu(16'h0111, 0, 1, 1, 3'b010, 10'd4,  0, 0, 0)); // R1=R1+R1 reads old 05
      tbl.push_back(mk_alu(16'h00A1, 1, 0, 1, 3'b011, 10'd5,  1, 0, 0)); // R1 now 0A

      // Call/return sequences (flags stay z=1 c=0)
      seq.push_back(mk_ctl(16'h0010, 0, 0, 0, 10'h010, 1, 0, 0));
      seq.push_back(mk_ctl(16'h0100, 0, 1, 0, 10'h100, 1, 0, 0));
      seq.push_back(mk_ctl(16'h0200, 0, 1, 0, 10'h200, 1, 0, 0));
      seq.push_back(mk_ctl(16'h0000, 1, 0, 1, 10'h101, 1, 0, 0));
      seq.push_back(mk_ctl(16'h0000, 1, 0, 1, 10'h011, 1, 0, 0));
      seq.push_back(mk_ctl(16'h0040, 0, 1, 0, 10'h040, 1, 0, 0));        // push 012
      seq.push_back(mk_ctl(16'h0080, 0, 1, 0, 10'h080, 1, 0, 0));        // push 041
      seq.push_back(mk_ctl(16'h00C0, 0, 1, 0, 10'h0C0, 1, 0, 0));        // push 081
      seq.push_back(mk_ctl(16'h0100, 0, 1, 0, 10'h100, 1, 0, 0));        // push 0C1 (full)
      seq.push_back(mk_ctl(16'h0140, 0, 1, 0, 10'h140, 1, 0, 1));        // overflow
      seq.push_back(mk_ctl(16'h0000, 1, 0, 1, 10'h0C1, 1, 0, 1));
      seq.push_back(mk_ctl(16'h0000, 1, 0, 1, 10'h081, 1, 0, 1));
      seq.push_back(mk_ctl(16'h0000, 1, 0, 1, 10'h041, 1, 0, 1));
      seq.push_back(mk_ctl(16'h0000, 1, 0, 1, 10'h012, 1, 0, 1));
      seq.push_back(mk_ctl(16'h0000, 1, 0, 1, 10'h013, 1, 0, 1));        // underflow -> pc+1
      seq.push_back(mk_ctl(16'h0300, 0, 1, 0, 10'h300, 1, 0, 1));        // push 014
      seq.push_back(mk_ctl(16'h0155, 0, 1, 1, 10'h014, 1, 0, 1));        // ret wins
      seq.push_back(mk_ctl(16'h0000, 1, 0, 1, 10'h015, 1, 0, 1));        // stack was empty
      seq.push_back(mk_ctl(16'h02AA, 0, 1, 0, 10'h2AA, 1, 0, 1));        // push 016

      // Reset with random inputs for two edges
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         instr = IW'($urandom); s_inc = 1'($urandom); s_inm = 1'($urandom);
         we3 = 1'($urandom); wez = 1'($urandom); s_call = 1'($urandom);
         s_ret = 1'($urandom); op = 3'($urandom);
         @(posedge clk);
         #1;
      end
      chk("reset pc",      int'(pc),      0);
      chk("reset z",       int'(z),       0);
      chk("reset c",       int'(c),       0);
      chk("reset stk_err", int'(stk_err), 0);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("alu%0d", i));
      for (int i = 0; i < seq.size(); i++) apply(seq[i], $sformatf("stk%0d", i));

      // Reset beats an in-flight call and empties the stack
      reset = 1'b0;
      apply(mk_ctl(16'h01F0, 0, 1, 0, 10'h000, 0, 0, 0), "rst_call");
      reset = 1'b1;
      apply(mk_ctl(16'h0000, 1, 0, 1, 10'h001, 0, 0, 1), "rst_ret_empty");
      apply(mk_alu(16'h0100, 0, 0, 1, 3'b000, 10'd2, 1, 0, 1), "rst_r1_zero");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
